// File: rtl/aes128_encrypt_core_if.sv
// Plaintext/key request and ciphertext result bundle for aes128_encrypt_core.
// The host drives the master side and the core sits on the slave side.
interface aes128_encrypt_core_if;
  logic [0:127] i_plain;
  logic [0:127] i_key;
  logic [0:127] o_cipher;
  logic         o_valid;

  modport master (output i_plain, output i_key, input  o_cipher, input  o_valid);
  modport slave  (input  i_plain, input  i_key, output o_cipher, output o_valid);
endinterface

// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 encryptor, one round per clock, free-running every 11 cycles.
// Optional AES_INPUT_REG_EN adds a register stage on plaintext/key ahead of LOAD.
module aes128_encrypt_core (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  aes128_encrypt_core_if.slave   bus
);

  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned ROUND_W    = 4;
  localparam int unsigned LAST_ROUND = 10;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as x^254 (multiplicative inverse, 0 -> 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] b;
    sq = x;
    b  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      b  = gf_mul(b, sq);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [ROUND_W-1:0] rc);
    logic [7:0] r;
    case (rc)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [0:BLOCK_W-1] key_next(input logic [0:BLOCK_W-1] rk,
                                                  input logic [7:0]         rc_byte);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = rk[0  +: 32];
    w1 = rk[32 +: 32];
    w2 = rk[64 +: 32];
    w3 = rk[96 +: 32];
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc_byte, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // SubBytes fused with ShiftRows: out[row r, col c] = S(in[row r, col (c+r)%4])
  function automatic logic [0:BLOCK_W-1] sub_shift(input logic [0:BLOCK_W-1] s);
    logic [0:BLOCK_W-1] o;
    int src;
    o = '0;
    for (int n = 0; n < 16; n++) begin
      src = 4 * (((n / 4) + (n % 4)) % 4) + (n % 4);
      o[8*n +: 8] = sbox(s[8*src +: 8]);
    end
    return o;
  endfunction

  function automatic logic [0:BLOCK_W-1] mix_columns(input logic [0:BLOCK_W-1] s);
    logic [0:BLOCK_W-1] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      o[32*c +: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                       a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                       a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                       xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  logic [0:BLOCK_W-1] state_q;
  logic [0:BLOCK_W-1] rk_q;
  logic [0:BLOCK_W-1] cipher_q;
  logic               valid_q;
  logic [ROUND_W-1:0] rc_q;

  logic [0:BLOCK_W-1] load_plain_c;
  logic [0:BLOCK_W-1] load_key_c;
  logic [0:BLOCK_W-1] rk_next_c;
  logic [0:BLOCK_W-1] sub_shift_c;
  logic [0:BLOCK_W-1] round_out_c;
  logic [0:BLOCK_W-1] final_out_c;

`ifdef AES_INPUT_REG_EN
  logic [0:BLOCK_W-1] plain_q;
  logic [0:BLOCK_W-1] key_q;

  // Free-running input capture; LOAD sees the values from one edge earlier
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      plain_q <= '0;
      key_q   <= '0;
    end else begin
      plain_q <= bus.i_plain;
      key_q   <= bus.i_key;
    end
  end

  assign load_plain_c = plain_q;
  assign load_key_c   = key_q;
`else
  assign load_plain_c = bus.i_plain;
  assign load_key_c   = bus.i_key;
`endif

  always_comb begin
    rk_next_c   = key_next(rk_q, rcon(rc_q));
    sub_shift_c = sub_shift(state_q);
    round_out_c = mix_columns(sub_shift_c) ^ rk_next_c;
    final_out_c = sub_shift_c ^ rk_next_c;
  end

  // rc=0 loads, rc=1..9 run full rounds, rc=10 runs the final round and publishes
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= '0;
      rk_q     <= '0;
      cipher_q <= '0;
      valid_q  <= 1'b0;
      rc_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      if (rc_q == '0) begin
        state_q <= load_plain_c ^ load_key_c;
        rk_q    <= load_key_c;
        rc_q    <= ROUND_W'(1);
      end else if (rc_q == ROUND_W'(LAST_ROUND)) begin
        cipher_q <= final_out_c;
        valid_q  <= 1'b1;
        rc_q     <= '0;
      end else begin
        state_q <= round_out_c;
        rk_q    <= rk_next_c;
        rc_q    <= rc_q + ROUND_W'(1);
      end
    end
  end

  assign bus.o_cipher = cipher_q;
  assign bus.o_valid  = valid_q;

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Self-checking bench for aes128_encrypt_core: known-answer vectors through a
// ciphertext scoreboard, plus mid-block input change and mid-block reset sequences.
module tb_aes128_encrypt_core;

  logic i_clock = 1'b0;
  logic i_reset_n;

  aes128_encrypt_core_if bus ();

  aes128_encrypt_core dut (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [0:127] key;
    logic [0:127] plain;
    logic [0:127] exp;
  } vec_t;

  vec_t vecs [3];

  int checks = 0;
  int passes = 0;

  logic [0:127] sb_q [$];
  logic [0:127] cur_exp;
  logic [0:127] exp_cipher;
  bit           exp_valid;
  bit           in_reset;
  int           m_rc;
  int           cyc;
  int           dut_last_valid;
  int           rel_cyc;
  bit           ok;

  task automatic check128(input string name, input logic [0:127] act, input logic [0:127] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic set_vec(input int i);
    bus.i_plain = vecs[i].plain;
    bus.i_key   = vecs[i].key;
    cur_exp     = vecs[i].exp;
  endtask

  // One clock: advance the block-timing model at the edge, check outputs at the falling edge
  task automatic step();
    @(posedge i_clock);
    cyc++;
    exp_valid = 1'b0;
    if (!in_reset) begin
      if (m_rc == 0) begin
        sb_q.push_back(cur_exp);
        m_rc = 1;
      end else if (m_rc == 10) begin
        m_rc      = 0;
        exp_valid = 1'b1;
        if (sb_q.size() > 0) exp_cipher = sb_q.pop_front();
      end else begin
        m_rc++;
      end
    end
    @(negedge i_clock);
    check_int("o_valid", int'(bus.o_valid), int'(exp_valid));
    check128("o_cipher", bus.o_cipher, exp_cipher);
    if (bus.o_valid === 1'b1) begin
      if (dut_last_valid >= 0) check_int("valid_period", cyc - dut_last_valid, 11);
      dut_last_valid = cyc;
    end
  endtask

  task automatic wait_rc(input int target, input string name);
    for (int k = 0; k < 30 && m_rc != target; k++) step();
    if (m_rc != target) check_int({name, "_timeout"}, m_rc, target);
  endtask

  task automatic wait_valid(input string name, output bit found);
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (bus.o_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check_int({name, "_timeout"}, 0, 1);
  endtask

  task automatic enter_reset();
    i_reset_n      = 1'b0;
    in_reset       = 1'b1;
    sb_q.delete();
    m_rc           = 0;
    exp_cipher     = '0;
    dut_last_valid = -1;
  endtask

  initial begin
    vecs[0] = '{key:   128'h2b7e151628aed2a6abf7158809cf4f3c,
                plain: 128'h3243f6a8885a308d313198a2e0370734,
                exp:   128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{key:   128'h000102030405060708090a0b0c0d0e0f,
                plain: 128'h00112233445566778899aabbccddeeff,
                exp:   128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{key:   128'h0,
                plain: 128'h0,
                exp:   128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    cyc = 0;
    i_reset_n = 1'b1;
    set_vec(0);
    #1;
    enter_reset();
    #5;
    check128("reset_cipher", bus.o_cipher, 128'h0);
    check_int("reset_valid", int'(bus.o_valid), 0);
    step();
    step();
    i_reset_n = 1'b1;
    in_reset  = 1'b0;
    rel_cyc   = cyc;

    // First block after release: LOAD on the next edge, result 10 edges later
    wait_valid("first_block", ok);
    check_int("first_latency", cyc - rel_cyc, 11);
    check128("first_cipher", bus.o_cipher, vecs[0].exp);

    // Known-answer table, two full blocks per vector
    for (int i = 0; i < 3; i++) begin
      set_vec(i);
      repeat (23) step();
      check128($sformatf("vec%0d_cipher", i), bus.o_cipher, vecs[i].exp);
    end
    repeat (22) step();
    check128("zero_republish", bus.o_cipher, vecs[2].exp);

    // Input change at rc=5 must not disturb the block in flight
    set_vec(0);
    wait_rc(1, "mid_load");
    wait_rc(5, "mid_rc5");
    set_vec(1);
    wait_valid("mid_old", ok);
    check128("midblock_old", bus.o_cipher, vecs[0].exp);
    wait_valid("mid_new", ok);
    check128("midblock_new", bus.o_cipher, vecs[1].exp);

    // Asynchronous reset at rc=7 clears outputs at once and aborts the block
    set_vec(0);
    wait_rc(1, "rst_load");
    wait_rc(7, "rst_rc7");
    #2;
    enter_reset();
    #1;
    check128("midreset_cipher", bus.o_cipher, 128'h0);
    check_int("midreset_valid", int'(bus.o_valid), 0);
    step();
    step();
    i_reset_n = 1'b1;
    in_reset  = 1'b0;
    rel_cyc   = cyc;
    wait_valid("post_reset", ok);
    check_int("post_reset_latency", cyc - rel_cyc, 11);
    check128("post_reset_cipher", bus.o_cipher, vecs[0].exp);
    repeat (3) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
